// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite slave bus bundle for axi_lite_regfile.
//
// Carries the five AXI4-Lite channels (AW, W, B, AR, R). Clock and reset are
// not part of the bundle; they stay plain ports on the register file.
//
// Parameters:
//   DATA_WIDTH  data bus width; wstrb is DATA_WIDTH/8+1 bits, its MSB unused
//   ADDR_WIDTH  address width
//   RESP_WIDTH  bresp/rresp width
//
// Modports:
//   master  drives addresses, data, strobes, valids and bready/rready
//   slave   drives readies, responses, read data and bvalid/rvalid

interface axi_lite_regfile_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3
);

  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8:0]   wstrb;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file with two R/W registers, a sum and a write counter.
//
// Register map (byte offsets from BASE_ADDR):
//   +0  REG0    read/write
//   +4  REG1    read/write
//   +8  SUM     read-only, REG0 + REG1 modulo 2^DATA_WIDTH
//   +12 WCOUNT  read-only, number of writes answered OKAY (wraps)
// Unaligned, unmapped and read-only-target accesses answer SLVERR (2) with
// rdata = 0; everything else answers OKAY (0).
//
// Build option:
//   AXIL_REGFILE_READBACK_EN  when defined, +0/+4 read back REG0/REG1 with
//                             OKAY; when undefined those reads answer SLVERR
//                             with rdata = 0 (writes are unaffected).
//
// Ports:
//   s_axi_aclk    clock
//   s_axi_areset  asynchronous, active-high reset
//   s_axi         AXI4-Lite slave bundle (axi_lite_regfile_if.slave)

module axi_lite_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  axi_lite_regfile_if.slave s_axi
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] BaseAddr  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OffReg0   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OffReg1   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OffSum    = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] OffWcount = ADDR_WIDTH'(12);

  localparam logic [RESP_WIDTH-1:0] RespOkay   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RespSlvErr = RESP_WIDTH'(2);

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] reg0_q, reg1_q, wcount_q;
  logic [DATA_WIDTH-1:0] sum;

  assign sum = reg0_q + reg1_q;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  wr_state_e             wr_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [RESP_WIDTH-1:0] bresp_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NumBytes-1:0]   w_strb_q;

  logic aw_hs, w_hs;
  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;

  // The strobe MSB carries no byte lane.
  logic unused_wstrb_msb;
  assign unused_wstrb_msb = s_axi.wstrb[NumBytes];

  // Commit happens on the edge of whichever handshake completes the pair;
  // address and data come either from the bus (this cycle) or from the latch.
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [NumBytes-1:0]   cm_strb;

  always_comb begin
    commit  = 1'b0;
    cm_addr = aw_addr_q;
    cm_data = w_data_q;
    cm_strb = w_strb_q;
    case (wr_state_q)
      W_IDLE: begin
        commit  = aw_hs & w_hs;
        cm_addr = s_axi.awaddr;
        cm_data = s_axi.wdata;
        cm_strb = s_axi.wstrb[NumBytes-1:0];
      end
      W_WAIT_DATA: begin
        commit  = w_hs;
        cm_data = s_axi.wdata;
        cm_strb = s_axi.wstrb[NumBytes-1:0];
      end
      W_WAIT_ADDR: begin
        commit  = aw_hs;
        cm_addr = s_axi.awaddr;
      end
      default: ;
    endcase
  end

  // Only REG0/REG1 are writable; everything else (incl. SUM/WCOUNT) is SLVERR.
  logic [ADDR_WIDTH-1:0] cm_off;
  logic                  cm_aligned, cm_is_reg0, cm_is_reg1, cm_okay;
  logic [RESP_WIDTH-1:0] cm_resp;

  assign cm_off     = cm_addr - BaseAddr;
  assign cm_aligned = (cm_addr[1:0] == 2'b00);
  assign cm_is_reg0 = cm_aligned & (cm_off == OffReg0);
  assign cm_is_reg1 = cm_aligned & (cm_off == OffReg1);
  assign cm_okay    = cm_is_reg0 | cm_is_reg1;
  assign cm_resp    = cm_okay ? RespOkay : RespSlvErr;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      reg0_q   <= '0;
      reg1_q   <= '0;
      wcount_q <= '0;
    end else if (commit && cm_okay) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (cm_strb[b]) begin
          if (cm_is_reg0) reg0_q[b*8 +: 8] <= cm_data[b*8 +: 8];
          if (cm_is_reg1) reg1_q[b*8 +: 8] <= cm_data[b*8 +: 8];
        end
      end
      // Counts every OKAY write, even one with no strobes; wraps naturally.
      wcount_q <= wcount_q + DATA_WIDTH'(1);
    end
  end

  // Write FSM: readies and the B channel are registered alongside the state.
  // Readies stay low in W_IDLE straight out of reset and rise on the first edge.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state_q <= W_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= cm_resp;
          end else if (aw_hs) begin
            wr_state_q <= W_WAIT_DATA;
            aw_addr_q  <= s_axi.awaddr;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
          end else if (w_hs) begin
            wr_state_q <= W_WAIT_ADDR;
            w_data_q   <= s_axi.wdata;
            w_strb_q   <= s_axi.wstrb[NumBytes-1:0];
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
          end else begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        W_WAIT_DATA: begin
          if (w_hs) begin
            wr_state_q <= W_RESP;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= cm_resp;
          end
        end
        W_WAIT_ADDR: begin
          if (aw_hs) begin
            wr_state_q <= W_RESP;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= cm_resp;
          end
        end
        W_RESP: begin
          // bvalid_q is always set here, so bready alone completes B.
          if (s_axi.bready) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RESP_WIDTH-1:0] rresp_q;

  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] rd_off;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [RESP_WIDTH-1:0] rd_resp;

  assign ar_hs  = s_axi.arvalid & arready_q;
  assign rd_off = s_axi.araddr - BaseAddr;

  // Sampled from the current register values, so a read landing on the same
  // edge as a write commit sees the pre-commit contents.
  always_comb begin
    rd_data = '0;
    rd_resp = RespSlvErr;
    if (s_axi.araddr[1:0] == 2'b00) begin
      case (rd_off)
`ifdef AXIL_REGFILE_READBACK_EN
        OffReg0: begin
          rd_data = reg0_q;
          rd_resp = RespOkay;
        end
        OffReg1: begin
          rd_data = reg1_q;
          rd_resp = RespOkay;
        end
`endif
        OffSum: begin
          rd_data = sum;
          rd_resp = RespOkay;
        end
        OffWcount: begin
          rd_data = wcount_q;
          rd_resp = RespOkay;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state_q <= R_DATA;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_data;
            rresp_q    <= rd_resp;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed vector table, a few
// hand-written multi-cycle sequences, then randomized traffic against a
// register-level reference model.

module tb_axi_lite_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 3;

`ifdef AXIL_REGFILE_READBACK_EN
  localparam bit Readback = 1'b1;
`else
  localparam bit Readback = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

  axi_lite_regfile #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESP_WIDTH(RW),
    .BASE_ADDR (0)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .s_axi       (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_reg0, m_reg1, m_wcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] m_write(input logic [7:0] a, input logic [31:0] d,
                                         input logic [4:0] s);
    if (a != 8'h00 && a != 8'h04) return 3'd2;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (a == 8'h00) m_reg0[8*b +: 8] = d[8*b +: 8];
        else            m_reg1[8*b +: 8] = d[8*b +: 8];
      end
    end
    m_wcount = m_wcount + 32'd1;
    return 3'd0;
  endfunction

  task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
    d = 32'h0;
    r = 3'd2;
    case (a)
      8'h00: if (Readback) begin d = m_reg0; r = 3'd0; end
      8'h04: if (Readback) begin d = m_reg1; r = 3'd0; end
      8'h08: begin d = m_reg0 + m_reg1; r = 3'd0; end
      8'h0C: begin d = m_wcount; r = 3'd0; end
      default: ;
    endcase
  endtask

  // Full write: AW/W each raised after their own delay, B held off b_dly cycles.
  // cyc returns how many edges it took to complete both handshakes.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [2:0] resp, output int cyc);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    logic [2:0] r0;
    cyc = 0;
    bus.awaddr = a;
    bus.wdata  = d;
    bus.wstrb  = s;
    while (!(aw_done && w_done) && cyc < 64) begin
      bus.awvalid = !aw_done && cyc >= aw_dly;
      bus.wvalid  = !w_done && cyc >= w_dly;
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      cyc++;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      if (!(aw_done && w_done)) check("bvalid_before_commit", bus.bvalid, 1'b0);
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    check("bvalid_at_commit", bus.bvalid, 1'b1);
    check("awready_in_resp", bus.awready, 1'b0);
    check("wready_in_resp", bus.wready, 1'b0);
    r0 = bus.bresp;
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      check("bvalid_held", bus.bvalid, 1'b1);
      check("bresp_stable", bus.bresp, r0);
      check("awready_held_low", bus.awready, 1'b0);
      check("wready_held_low", bus.wready, 1'b0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("bvalid_cleared", bus.bvalid, 1'b0);
    check("awready_after_b", bus.awready, 1'b1);
    check("wready_after_b", bus.wready, 1'b1);
    resp = r0;
  endtask

  task automatic axi_read(input logic [7:0] a, input int r_dly,
                          output logic [31:0] data, output logic [2:0] resp);
    int cyc = 0;
    bit fired = 0, f;
    bus.araddr = a;
    while (!fired && cyc < 64) begin
      bus.arvalid = 1'b1;
      f = bus.arready;
      @(posedge clk); #1;
      cyc++;
      fired = f;
    end
    bus.arvalid = 1'b0;
    check("rd_handshake", fired, 1'b1);
    check("rvalid_at_ar", bus.rvalid, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); #1;
      check("rvalid_held", bus.rvalid, 1'b1);
      check("rdata_stable", bus.rdata, data);
      check("arready_held_low", bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check("rvalid_cleared", bus.rvalid, 1'b0);
    check("arready_after_r", bus.arready, 1'b1);
  endtask

  typedef struct {
    bit          is_rd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          resp_dly;
    logic [2:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    forever begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    logic [2:0]  r;
    logic [31:0] d, md, pre_sum;
    logic [2:0]  mr, dummy;
    int          cyc;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0;  bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    m_reg0 = 0; m_reg1 = 0; m_wcount = 0;

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", bus.awready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_bresp", bus.bresp, 3'd0);
    check("rst_rresp", bus.rresp, 3'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", bus.awready, 1'b1);
    check("post_rst_wready", bus.wready, 1'b1);
    check("post_rst_arready", bus.arready, 1'b1);

    // ---- Directed vector table ----
    //                 rd  addr   data          strb   awd wd rd  resp  rdata
    vecs.push_back('{1'b0, 8'h00, 32'h00000005, 5'hF,  0, 0, 0, 3'd0, 32'h0});
    vecs.push_back('{1'b0, 8'h04, 32'h00000007, 5'hF,  0, 0, 5, 3'd0, 32'h0});
    vecs.push_back('{1'b1, 8'h08, 32'h0,        5'h0,  0, 0, 3, 3'd0, 32'h0000000C});
    vecs.push_back('{1'b1, 8'h0C, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h00000002});
    vecs.push_back('{1'b0, 8'h00, 32'hAABBCCDD, 5'h3,  3, 0, 0, 3'd0, 32'h0});
    vecs.push_back('{1'b1, 8'h00, 32'h0,        5'h0,  0, 0, 0,
                     Readback ? 3'd0 : 3'd2, Readback ? 32'h0000CCDD : 32'h0});
    vecs.push_back('{1'b1, 8'h08, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h0000CCE4});
    vecs.push_back('{1'b0, 8'h08, 32'h00001234, 5'hF,  0, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b1, 8'h02, 32'h0,        5'h0,  0, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b1, 8'h08, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h0000CCE4});
    vecs.push_back('{1'b1, 8'h0C, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h00000003});
    vecs.push_back('{1'b0, 8'h04, 32'hFFFFFFFF, 5'h0,  0, 2, 0, 3'd0, 32'h0});
    vecs.push_back('{1'b1, 8'h08, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h0000CCE4});
    vecs.push_back('{1'b1, 8'h0C, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h00000004});
    vecs.push_back('{1'b0, 8'h04, 32'hFFFFFFFF, 5'h10, 0, 0, 0, 3'd0, 32'h0});
    vecs.push_back('{1'b1, 8'h04, 32'h0,        5'h0,  0, 0, 0,
                     Readback ? 3'd0 : 3'd2, Readback ? 32'h00000007 : 32'h0});
    vecs.push_back('{1'b0, 8'h10, 32'h00000001, 5'hF,  0, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b0, 8'h05, 32'h00000001, 5'hF,  1, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b0, 8'h0C, 32'h00000001, 5'hF,  0, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b1, 8'h0C, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h00000005});
    vecs.push_back('{1'b0, 8'h04, 32'h00FF0000, 5'h4,  0, 0, 0, 3'd0, 32'h0});
    vecs.push_back('{1'b1, 8'h08, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h00FFCCE4});
    vecs.push_back('{1'b1, 8'h0D, 32'h0,        5'h0,  0, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b1, 8'h40, 32'h0,        5'h0,  0, 0, 0, 3'd2, 32'h0});
    vecs.push_back('{1'b1, 8'h0C, 32'h0,        5'h0,  0, 0, 0, 3'd0, 32'h00000006});

    foreach (vecs[i]) begin
      if (vecs[i].is_rd) begin
        axi_read(vecs[i].addr, vecs[i].resp_dly, d, r);
        check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly,
                  vecs[i].resp_dly, r, cyc);
        dummy = m_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
      end
    end

    // ---- Read of SUM on the same edge as a REG0 write commit ----
    pre_sum = m_reg0 + m_reg1;
    bus.awaddr = 8'h00; bus.wdata = 32'h00000100; bus.wstrb = 5'hF; bus.araddr = 8'h08;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("same_edge_rvalid", bus.rvalid, 1'b1);
    check("same_edge_rdata_pre_commit", bus.rdata, pre_sum);
    check("same_edge_bvalid", bus.bvalid, 1'b1);
    check("same_edge_bresp", bus.bresp, 3'd0);
    dummy = m_write(8'h00, 32'h00000100, 5'hF);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("same_edge_bvalid_done", bus.bvalid, 1'b0);
    check("same_edge_rvalid_done", bus.rvalid, 1'b0);
    axi_read(8'h08, 0, d, r);
    m_read(8'h08, md, mr);
    check("post_commit_sum", d, md);

    // ---- Stalled B then immediate back-to-back write ----
    axi_write(8'h04, 32'h00000011, 5'hF, 0, 0, 5, r, cyc);
    check("stall_bresp", r, m_write(8'h04, 32'h00000011, 5'hF));
    axi_write(8'h00, 32'h00000022, 5'hF, 0, 0, 0, r, cyc);
    check("b2b_accept_cycles", cyc, 1);
    check("b2b_bresp", r, m_write(8'h00, 32'h00000022, 5'hF));
    axi_read(8'h08, 0, d, r);
    check("b2b_sum", d, 32'h00000033);

    // ---- WCOUNT wrap from a forced all-ones value ----
    force dut.wcount_q = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.wcount_q;
    m_wcount = 32'hFFFFFFFF;
    axi_read(8'h0C, 0, d, r);
    check("wcount_forced", d, 32'hFFFFFFFF);
    axi_write(8'h04, 32'h0, 5'h0, 0, 0, 0, r, cyc);
    check("wrap_bresp", r, m_write(8'h04, 32'h0, 5'h0));
    axi_read(8'h0C, 0, d, r);
    check("wcount_wrapped", d, 32'h0);
    check("wcount_model_wrapped", m_wcount, 32'h0);

    // ---- Randomized traffic against the model ----
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      int sel;
      sel = $urandom_range(0, 5);
      if (sel < 4) a = 8'(sel * 4);
      else if (sel == 4) a = 8'($urandom_range(0, 15)) | 8'h01;
      else a = 8'($urandom_range(16, 255));
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] wd;
        logic [4:0]  ws;
        wd = $urandom;
        ws = 5'($urandom_range(0, 31));
        axi_write(a, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  r, cyc);
        check($sformatf("rand%0d_bresp_a%02h", i, a), r, m_write(a, wd, ws));
      end else begin
        axi_read(a, $urandom_range(0, 2), d, r);
        m_read(a, md, mr);
        check($sformatf("rand%0d_rresp_a%02h", i, a), r, mr);
        check($sformatf("rand%0d_rdata_a%02h", i, a), d, md);
      end
    end

    // ---- Reset while waiting for write data ----
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    check("wait_data_awready", bus.awready, 1'b0);
    check("wait_data_wready", bus.wready, 1'b1);
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 5'hF;
    rst = 1'b1;
    #1;
    check("async_rst_awready", bus.awready, 1'b0);
    check("async_rst_wready", bus.wready, 1'b0);
    check("async_rst_arready", bus.arready, 1'b0);
    check("async_rst_bvalid", bus.bvalid, 1'b0);
    m_reg0 = 0; m_reg1 = 0; m_wcount = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_awready", bus.awready, 1'b0);
    check("rst_hold_bvalid", bus.bvalid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_awready", bus.awready, 1'b1);
    check("rel_bvalid", bus.bvalid, 1'b0);
    @(posedge clk); #1;
    check("rel_bvalid_later", bus.bvalid, 1'b0);
    axi_read(8'h08, 0, d, r);
    check("rst_sum_zero", d, 32'h0);
    axi_read(8'h0C, 0, d, r);
    check("rst_wcount_zero", d, 32'h0);
    axi_read(8'h00, 0, d, r);
    m_read(8'h00, md, mr);
    check("rst_reg0_rdata", d, md);
    check("rst_reg0_rresp", r, mr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
